// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED shift-display sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        ROT_L  = 2'd0,
        ROT_R  = 2'd1,
        BOUNCE = 2'd2,
        BLINK  = 2'd3
    } mode_t;

    // FSM encodings stay plain constants so older code can compare raw bits.
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t RUN   = 2'd1;
    localparam state_t PAUSE = 2'd2;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } dir_t;

    localparam logic [7:0] LED_RESET = 8'h01;

    function automatic logic [7:0] onehot(input logic [2:0] p);
        return LED_RESET << p;
    endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Shift-time prescaler: counts RUN cycles and flags the last cycle of each step period.
module step_tick_gen #(
    parameter int SHIFT_TIME = 50_000_000,
    parameter int CNT_W      = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       restart,
    input  logic [1:0] speed,
    output logic       step,
    output logic       tick
);

    localparam logic [CNT_W-1:0] BASE = CNT_W'(SHIFT_TIME);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_q;

    // Exact-equality compare so a shorter re-latched period can never be overshot.
    assign step = enable && (cnt == period_q - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            period_q <= BASE;
            tick     <= 1'b0;
        end else begin
            tick <= step;
            if (restart || step) begin
                cnt      <= '0;
                period_q <= BASE >> speed;
            end else if (enable) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED sequencer top: RUN/PAUSE/IDLE FSM plus pattern stepping on each prescaler tick.
// Optional build macro LED_DIMMER_EN adds a duty input and 3-bit PWM gating of the LEDs.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int SHIFT_TIME = 50_000_000,
    parameter int CNT_W      = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic [1:0] mode,
    input  logic [1:0] speed,
`ifdef LED_DIMMER_EN
    input  logic [2:0] duty,
`endif
    output logic [7:0] LED,
    output logic       running,
    output logic       tick
);

    state_t     state, state_nx;
    logic [2:0] pos, pos_nx;
    dir_t       dir, dir_nx;
    logic       blink_ph, ph_nx;
    logic [7:0] pat, pat_nx;
    logic       step;
    logic       cnt_enable;
    logic       cnt_restart;

    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (start && !stop) state_nx = RUN;
                RUN:     if (stop) state_nx = PAUSE;
                PAUSE:   if (stop) state_nx = IDLE;
                         else if (start) state_nx = RUN;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Counting stops on the very edge a stop/clear lands, so PAUSE freezes the current count.
    assign cnt_enable  = (state == RUN) && (state_nx == RUN);
    assign cnt_restart = (state == IDLE) || (state_nx == IDLE);

    step_tick_gen #(
        .SHIFT_TIME(SHIFT_TIME),
        .CNT_W     (CNT_W)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (cnt_enable),
        .restart(cnt_restart),
        .speed  (speed),
        .step   (step),
        .tick   (tick)
    );

    always_comb begin
        pos_nx = pos;
        dir_nx = dir;
        ph_nx  = blink_ph;
        pat_nx = pat;
        case (mode_t'(mode))
            ROT_L: begin
                pos_nx = pos + 3'd1;
                pat_nx = onehot(pos_nx);
            end
            ROT_R: begin
                pos_nx = pos - 3'd1;
                pat_nx = onehot(pos_nx);
            end
            BOUNCE: begin
                if (dir == LEFT) begin
                    if (pos == 3'd7) begin
                        dir_nx = RIGHT;
                        pos_nx = 3'd6;
                    end else begin
                        pos_nx = pos + 3'd1;
                    end
                end else begin
                    if (pos == 3'd0) begin
                        dir_nx = LEFT;
                        pos_nx = 3'd1;
                    end else begin
                        pos_nx = pos - 3'd1;
                    end
                end
                pat_nx = onehot(pos_nx);
            end
            BLINK: begin
                ph_nx  = ~blink_ph;
                pat_nx = ph_nx ? 8'hFF : 8'h00;
            end
            default: pat_nx = pat;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pos      <= 3'd0;
            dir      <= LEFT;
            blink_ph <= 1'b0;
            pat      <= LED_RESET;
        end else begin
            state <= state_nx;
            if (state_nx == IDLE) begin
                pos      <= 3'd0;
                dir      <= LEFT;
                blink_ph <= 1'b0;
                pat      <= LED_RESET;
            end else if (step) begin
                pos      <= pos_nx;
                dir      <= dir_nx;
                blink_ph <= ph_nx;
                pat      <= pat_nx;
            end
        end
    end

    assign running = (state == RUN);

`ifdef LED_DIMMER_EN
    logic [2:0] pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt <= 3'd0;
        else        pwm_cnt <= pwm_cnt + 3'd1;
    end

    assign LED = pat & {8{pwm_cnt <= duty}};
`else
    assign LED = pat;
`endif

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed scoreboard bench for led_seq_ctrl with SHIFT_TIME=8.
// Expected LED values come from a behavioural pattern model pushed into a queue per step.
module tb_led_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start, stop, clear;
    logic [1:0] mode, speed;
`ifdef LED_DIMMER_EN
    logic [2:0] duty;
`endif
    logic [7:0] LED;
    logic       running;
    logic       tick;

    int checks   = 0;
    int failures = 0;

    logic [7:0] expQ[$];
    int         mpos;
    int         mdir;
    logic       mph;

    led_seq_ctrl #(.SHIFT_TIME(8), .CNT_W(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .stop   (stop),
        .clear  (clear),
        .mode   (mode),
        .speed  (speed),
`ifdef LED_DIMMER_EN
        .duty   (duty),
`endif
        .LED    (LED),
        .running(running),
        .tick   (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tickClk();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic p, input logic c);
        start = s;
        stop  = p;
        clear = c;
        tickClk();
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
    endtask

    task automatic modelReset();
        mpos = 0;
        mdir = 0;
        mph  = 1'b0;
    endtask

    task automatic modelStep(input logic [1:0] m, output logic [7:0] e);
        logic [7:0] one;
        one = 8'h01;
        case (m)
            2'd0: mpos = (mpos + 1) % 8;
            2'd1: mpos = (mpos + 7) % 8;
            2'd2: begin
                if (mdir == 0) begin
                    if (mpos == 7) begin mdir = 1; mpos = 6; end
                    else mpos = mpos + 1;
                end else begin
                    if (mpos == 0) begin mdir = 0; mpos = 1; end
                    else mpos = mpos - 1;
                end
            end
            default: mph = ~mph;
        endcase
        if (m == 2'd3) e = mph ? 8'hFF : 8'h00;
        else           e = one << mpos;
    endtask

    task automatic waitTick(output int n);
        n = 0;
        do begin
            tickClk();
            n++;
        end while (tick !== 1'b1 && n < 64);
    endtask

    // Each step: predict, queue, wait for the DUT tick, then check spacing and LED.
    task automatic runSteps(input int count, input int gap);
        logic [7:0] e;
        int         n;
        for (int i = 0; i < count; i++) begin
            modelStep(mode, e);
            expQ.push_back(e);
            waitTick(n);
            checkOutput("step_gap", n, gap);
            e = expQ.pop_front();
            checkOutput("step_led", {24'd0, LED}, {24'd0, e});
        end
    endtask

    initial begin
        int onCycles;
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
        mode  = 2'd0;
        speed = 2'd0;
`ifdef LED_DIMMER_EN
        duty  = 3'd7;
`endif
        modelReset();
        tickClk();
        tickClk();
        checkOutput("reset_led", {24'd0, LED}, 32'h01);
        checkOutput("reset_running", {31'd0, running}, 32'd0);
        checkOutput("reset_tick", {31'd0, tick}, 32'd0);
        rst_n = 1'b1;
        tickClk();

        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("idle_start_stop_running", {31'd0, running}, 32'd0);

        $display("[TB] rotate-left run");
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("run_running", {31'd0, running}, 32'd1);
        runSteps(8, 8);

        $display("[TB] pause at cnt=5 and resume");
        for (int i = 0; i < 5; i++) tickClk();
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("pause_running", {31'd0, running}, 32'd0);
        for (int i = 0; i < 6; i++) tickClk();
        checkOutput("pause_led_frozen", {24'd0, LED}, 32'h01);
        checkOutput("pause_tick", {31'd0, tick}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("resume_running", {31'd0, running}, 32'd1);
        runSteps(1, 3);

        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("startstop_running", {31'd0, running}, 32'd0);
        checkOutput("startstop_led", {24'd0, LED}, 32'h02);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("pause_stop_led", {24'd0, LED}, 32'h01);
        checkOutput("pause_stop_running", {31'd0, running}, 32'd0);
        modelReset();

        $display("[TB] bounce run");
        mode = 2'd2;
        applyStimulus(1'b1, 1'b0, 1'b0);
        runSteps(15, 8);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("clear_led", {24'd0, LED}, 32'h01);
        checkOutput("clear_running", {31'd0, running}, 32'd0);
        modelReset();

        $display("[TB] fast speed, blink, back to rotate-right");
        mode  = 2'd0;
        speed = 2'd2;
        applyStimulus(1'b1, 1'b0, 1'b0);
        runSteps(3, 2);
        mode = 2'd3;
        runSteps(3, 2);
        mode = 2'd1;
        runSteps(1, 2);
        speed = 2'd1;
        runSteps(1, 2);
        runSteps(2, 4);

        for (int i = 0; i < 2; i++) tickClk();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_led", {24'd0, LED}, 32'h01);
        checkOutput("async_reset_running", {31'd0, running}, 32'd0);
        checkOutput("async_reset_tick", {31'd0, tick}, 32'd0);
        tickClk();
        rst_n = 1'b1;
        tickClk();

`ifdef LED_DIMMER_EN
        duty = 3'd3;
        onCycles = 0;
        for (int i = 0; i < 8; i++) begin
            tickClk();
            if (LED == 8'h01) onCycles++;
        end
        checkOutput("dimmer_on_cycles", onCycles, 4);
`else
        onCycles = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
